// File: rtl/conf_loader.sv
// rtl/conf_loader.sv - daisy-chained configuration bitstream loader with shadow/active registers
//
// Purpose: shifts W-bit configuration words into a shadow register, forwards
// overflow words to the next tile once the shadow is full, and copies the
// shadow into the active configuration vector c on a commit strobe.
//
// Ports:
//   clk         sole clock
//   rst         synchronous, active-high reset
//   din         incoming configuration word
//   din_valid   din holds a word
//   din_ready   loader accepts din this cycle
//   dout        word forwarded to the downstream loader
//   dout_valid  dout holds a word
//   dout_ready  downstream accepts dout
//   commit      single-cycle strobe: copy shadow to c
//   c           active configuration, registered
//   full        shadow holds NWORDS words
//   loaded      at least one successful commit since reset
//   err         sticky: commit attempted while not full
module conf_loader #(
  parameter int CONF_WIDTH = 64,
  parameter int W          = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [W-1:0]          din,
  input  logic                  din_valid,
  output logic                  din_ready,
  output logic [W-1:0]          dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  input  logic                  commit,
  output logic [CONF_WIDTH-1:0] c,
  output logic                  full,
  output logic                  loaded,
  output logic                  err
);

  localparam int NWORDS = (CONF_WIDTH + W - 1) / W;
  localparam int SHW    = NWORDS * W;
  localparam int CW     = $clog2(NWORDS + 1);

  localparam logic [CW-1:0] CNT_LAST = CW'(NWORDS - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(NWORDS);

  typedef enum logic {S_FILL, S_FULL} state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [SHW-1:0]  sh;
  logic [SHW-1:0]  sh_shift;
  logic            accept;

  // Newest word enters at the MSB end; oldest word sits in sh[W-1:0].
  generate
    if (NWORDS == 1) begin : g_single
      assign sh_shift = din;
    end else begin : g_multi
      assign sh_shift = {din, sh[SHW-1:W]};
    end
  endgenerate

  assign accept = din_valid && din_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FILL;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic: FULL is only left through reset.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    if (state == S_FILL && accept) begin
      if (cnt == CNT_LAST) begin
        state_nxt = S_FULL;
        cnt_nxt   = CNT_FULL;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  // Output logic. In FULL the loader is a pass-through stage, so handshakes
  // follow the downstream side combinationally. Reset forces the stream idle.
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout       = '0;
    full       = (state == S_FULL);
    if (!rst) begin
      case (state)
        S_FILL: begin
          din_ready = 1'b1;
        end
        S_FULL: begin
          dout       = sh[W-1:0];
          dout_valid = din_valid;
          din_ready  = dout_ready;
        end
        default: begin
          din_ready = 1'b0;
        end
      endcase
    end
  end

  // Shadow and active registers. A commit on a shifting edge captures the
  // pre-edge shadow because both read sh before the edge updates it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh     <= '0;
      c      <= '0;
      loaded <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (accept) begin
        sh <= sh_shift;
      end
      if (commit) begin
        if (state == S_FULL) begin
          c      <= sh[CONF_WIDTH-1:0];
          loaded <= 1'b1;
        end else begin
          err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conf_loader.sv
// tb/tb_conf_loader.sv - directed self-checking bench for conf_loader
module tb_conf_loader;

  localparam int CONF_WIDTH = 20;
  localparam int W          = 8;

  logic                  clk;
  logic                  rst;
  logic [W-1:0]          din;
  logic                  din_valid;
  logic                  din_ready;
  logic [W-1:0]          dout;
  logic                  dout_valid;
  logic                  dout_ready;
  logic                  commit;
  logic [CONF_WIDTH-1:0] c;
  logic                  full;
  logic                  loaded;
  logic                  err;

  int n_cmp = 0;
  int n_err = 0;

  conf_loader #(.CONF_WIDTH(CONF_WIDTH), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .commit     (commit),
    .c          (c),
    .full       (full),
    .loaded     (loaded),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // All tasks start and end just after a falling edge.
  task automatic push(input logic [W-1:0] w);
    din       = w;
    din_valid = 1'b1;
    @(negedge clk);
    din_valid = 1'b0;
    #1;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    commit     = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_c",          c,          32'h0);
    check("rst_full",       full,       32'h0);
    check("rst_loaded",     loaded,     32'h0);
    check("rst_err",        err,        32'h0);
    check("rst_din_ready",  din_ready,  32'h0);
    check("rst_dout_valid", dout_valid, 32'h0);
    check("rst_dout",       dout,       32'h0);
    rst = 1'b0;
    #1;
    check("rel_din_ready", din_ready, 32'h1);

    // Basic load and commit
    push(8'hA5);
    push(8'h3C);
    check("load_full_2w", full, 32'h0);
    push(8'hFF);
    check("load_full_3w",  full,       32'h1);
    check("load_dout_vld", dout_valid, 32'h0);
    do_commit();
    check("load_c",      c,      32'hF3CA5);
    check("load_loaded", loaded, 32'h1);
    check("load_err",    err,    32'h0);

    // Chain forwarding with backpressure
    din        = 8'h11;
    din_valid  = 1'b1;
    dout_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("stall_din_ready",  din_ready,  32'h0);
      check("stall_dout_valid", dout_valid, 32'h1);
      check("stall_dout",       dout,       32'hA5);
      @(negedge clk);
      #1;
    end
    dout_ready = 1'b1;
    #1;
    check("rel_din_ready_fwd", din_ready, 32'h1);
    check("rel_dout",          dout,      32'hA5);
    @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    #1;
    check("fwd_next_dout", dout, 32'h3C);
    check("fwd_c_stable",  c,    32'hF3CA5);
    check("fwd_full",      full, 32'h1);
    do_commit();
    check("fwd_commit_c", c, 32'h1FF3C);

    // Reset mid-load
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_c",      c,      32'h0);
    check("rst2_full",   full,   32'h0);
    check("rst2_loaded", loaded, 32'h0);
    push(8'h77);
    rst = 1'b1;
    #1;
    check("mid_rst_din_ready", din_ready, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    push(8'hA5);
    push(8'h3C);
    check("mid_restart_full", full, 32'h0);

    // Early commit
    do_commit();
    check("early_c",      c,      32'h0);
    check("early_err",    err,    32'h1);
    check("early_loaded", loaded, 32'h0);
    push(8'hFF);
    check("early_full3", full, 32'h1);
    check("early_err_sticky", err, 32'h1);

    // Simultaneous commit and shift
    din        = 8'h11;
    din_valid  = 1'b1;
    dout_ready = 1'b1;
    commit     = 1'b1;
    #1;
    check("sim_dout_pre", dout, 32'hA5);
    @(negedge clk);
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    commit     = 1'b0;
    #1;
    check("sim_c_old",  c,      32'hF3CA5);
    check("sim_loaded", loaded, 32'h1);
    check("sim_err",    err,    32'h1);
    check("sim_dout",   dout,   32'h3C);
    do_commit();
    check("sim_commit_new_c", c,   32'h1FF3C);
    check("sim_err_final",    err, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
